bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares one single-port memory-side bus between three requesters: store-buffer write, store-buffer read and instruction fetch read.
- Sits between the fetch/stbuf request interfaces and the address-decoded bus fabric (TCM/CLINT).
- Provides round-robin arbitration, a registered command to the downstream port, wait-state tolerance and a one-cycle ack pulse back to the granted requester.

Parameters:
- FETCH_SIZE, 3, size code driven on arb_mem_size for fetch transactions (full bus width).
- TIMEOUT_CYCLES, 256, BUSY cycles without mem_arb_ack before the timeout fires (used only with the optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- fetch_arb_addr  input  `ADDR_WIDTH  fetch address
- fetch_arb_read_req  input  1  fetch read request; level, held until ack
- arb_fetch_data  output  `BUS_DATA_WIDTH  fetch read data, valid with ack
- arb_fetch_read_ack  output  1  one-cycle completion pulse
- stbuf_arb_read_addr  input  `ADDR_WIDTH  load address
- stbuf_arb_read_size  input  `SIZE_WIDTH  load size
- stbuf_arb_read_req  input  1  load request; level
- arb_stbuf_data  output  `REG_DATA_WIDTH  load data, valid with read ack
- arb_stbuf_read_ack  output  1  one-cycle pulse
- stbuf_arb_write_addr  input  `ADDR_WIDTH  store address
- stbuf_arb_write_size  input  `SIZE_WIDTH  store size
- stbuf_arb_data  input  `REG_DATA_WIDTH  store data
- stbuf_arb_write_req  input  1  store request; level
- arb_stbuf_write_ack  output  1  one-cycle pulse
- arb_mem_addr  output  `ADDR_WIDTH  registered command address
- arb_mem_size  output  `SIZE_WIDTH  registered command size
- arb_mem_data  output  `REG_DATA_WIDTH  registered write data
- arb_mem_rd  output  1  read command, high only in BUSY
- arb_mem_wr  output  1  write command, high only in BUSY
- mem_arb_ack  input  1  downstream completion; may be high in the first BUSY cycle
- mem_arb_rdata  input  `BUS_DATA_WIDTH  read data, valid with mem_arb_ack
- arb_bus_err  output  1  error pulse, coincident with an ack

Behaviour:
- Reset: asynchronous and active-high.
  - All outputs go to 0 and state goes to IDLE.
  - last_grant resets to 2 (fetch), so stbuf write has the highest priority first.
  - Any in-flight transaction is discarded, with no ack.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any request is high, pick the winner by round-robin.
  - Search order starts at (last_grant+1) mod 3 over {0 stwr, 1 strd, 2 fetch}.
  - Latch the winner's addr, size and data into the command registers; fetch uses FETCH_SIZE and data 0.
  - Update last_grant and go to BUSY.
  - With no request, stay in IDLE.
- BUSY:
  - arb_mem_rd or arb_mem_wr is high according to the grant; the command is stable for the whole state.
  - On mem_arb_ack, capture mem_arb_rdata (reads only) into the granted requester's data register and go to DONE.
  - Otherwise stay in BUSY (wait states are unbounded unless the optional feature is enabled).
- DONE:
  - Assert the granted requester's ack for exactly 1 cycle; return data is held until the next completion for that requester.
  - No arbitration happens in DONE. Next state is IDLE.
- Latency: request seen in IDLE at cycle 0, command in BUSY from cycle 1, ack at cycle k+1 where k is the mem_arb_ack cycle.
  - Minimum request-to-ack is 2 cycles; back-to-back grant period is 3 cycles.
- Requester rule:
  - The request is deasserted in the cycle after ack.
  - A request still high in the following IDLE cycle is a new request.
  - Deasserting a request during BUSY is illegal; the transaction completes and acks anyway.
  - Address, size and data inputs only need to be valid in the IDLE cycle the request is granted.
- Store read data is mem_arb_rdata[`REG_DATA_WIDTH-1:0]; fetch data is the full width.
- Only one requester is ever granted at a time, and only one ack is high per cycle.
- No address decode is done here; the downstream fabric decodes.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without mem_arb_ack.
  - When the count reaches TIMEOUT_CYCLES-1 without an ack, the arbiter goes to DONE. The granted ack pulses with arb_bus_err=1, and the returned data is 0.
  - rd/wr deassert on leaving BUSY.
  - mem_arb_ack in the timeout cycle wins: normal completion, err=0.
- Without the macro: there is no counter logic, arb_bus_err is tied to 0, and BUSY waits indefinitely.

Decomposition:
- Package bus_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, BUSY, DONE};
  - typedef enum logic[1:0] arb_src_t {SRC_STWR=0, SRC_STRD=1, SRC_FETCH=2};
  - constant ARB_SRC_NUM=3.
- One sub-module, bus_rr_picker: a combinational 3-way round-robin pick from the request vector and last_grant, producing a one-hot grant plus a valid flag.

Test Plan:
- Single fetch from reset, addr 0x80000000, mem_arb_ack in the first BUSY cycle, rdata 0x1122334455667788 -> arb_mem_rd high for 1 cycle with size FETCH_SIZE; arb_fetch_read_ack pulses 2 cycles after the request with that data.
- All three requests held from reset -> grants in order stwr, strd, fetch, with acks spaced 3 cycles apart. Re-raising stwr after its ack -> it is served after fetch.
- Store 0x80001000, size 2, data 0xDEADBEEF, with 4 wait cycles -> arb_mem_wr and the command stay stable for 5 cycles; arb_stbuf_write_ack appears 1 cycle after mem_arb_ack.
- rst asserted mid-BUSY (asynchronous, not edge-aligned) -> rd/wr and all acks drop immediately; after release, stwr has priority and no stale ack appears.
- Load with rdata 0xAAAA_BBBB_CCCC_DDDD -> arb_stbuf_data is 0xCCCCDDDD when `REG_DATA_WIDTH=32 (low bits only); arb_fetch_data is unchanged.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no mem_arb_ack -> after 8 BUSY cycles the ack pulses with arb_bus_err=1 and data 0, and the FSM returns to IDLE.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types for the three-way memory bus arbiter.
// The width macros default here when the build does not supply them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 64
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 2
`endif

package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SRC_STWR  = 2'd0,
    SRC_STRD  = 2'd1,
    SRC_FETCH = 2'd2
  } arb_src_t;

  localparam int unsigned ARB_SRC_NUM = 3;

  function automatic arb_src_t onehot_to_src(input logic [ARB_SRC_NUM-1:0] oh);
    arb_src_t src;
    if (oh[0]) begin
      src = SRC_STWR;
    end else if (oh[1]) begin
      src = SRC_STRD;
    end else begin
      src = SRC_FETCH;
    end
    return src;
  endfunction

endpackage

// File: rtl/bus_arb_rr_picker.sv
// Combinational 3-way round-robin pick: search starts one past the last grant.
// Produces a one-hot grant and a valid flag.
module bus_rr_picker
  import bus_arb_pkg::*;
(
  input  logic [ARB_SRC_NUM-1:0] req_i,
  input  arb_src_t               last_grant_i,
  output logic [ARB_SRC_NUM-1:0] gnt_o,
  output logic                   valid_o
);

  always_comb begin
    gnt_o = '0;
    case (last_grant_i)
      SRC_STWR: begin
        if (req_i[1])      gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      SRC_STRD: begin
        if (req_i[2])      gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if (req_i[0])      gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between store write, store read and fetch.
// Define BUS_ARB_TIMEOUT_EN to add a BUSY watchdog that completes with arb_bus_err.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned FETCH_SIZE     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [`ADDR_WIDTH-1:0]     fetch_arb_addr,
  input  logic                       fetch_arb_read_req,
  output logic [`BUS_DATA_WIDTH-1:0] arb_fetch_data,
  output logic                       arb_fetch_read_ack,
  input  logic [`ADDR_WIDTH-1:0]     stbuf_arb_read_addr,
  input  logic [`SIZE_WIDTH-1:0]     stbuf_arb_read_size,
  input  logic                       stbuf_arb_read_req,
  output logic [`REG_DATA_WIDTH-1:0] arb_stbuf_data,
  output logic                       arb_stbuf_read_ack,
  input  logic [`ADDR_WIDTH-1:0]     stbuf_arb_write_addr,
  input  logic [`SIZE_WIDTH-1:0]     stbuf_arb_write_size,
  input  logic [`REG_DATA_WIDTH-1:0] stbuf_arb_data,
  input  logic                       stbuf_arb_write_req,
  output logic                       arb_stbuf_write_ack,
  output logic [`ADDR_WIDTH-1:0]     arb_mem_addr,
  output logic [`SIZE_WIDTH-1:0]     arb_mem_size,
  output logic [`REG_DATA_WIDTH-1:0] arb_mem_data,
  output logic                       arb_mem_rd,
  output logic                       arb_mem_wr,
  input  logic                       mem_arb_ack,
  input  logic [`BUS_DATA_WIDTH-1:0] mem_arb_rdata,
  output logic                       arb_bus_err
);

  arb_state_t                 state_q, state_d;
  arb_src_t                   last_grant_q, last_grant_d;
  arb_src_t                   grant_q, grant_d;
  logic [`ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [`SIZE_WIDTH-1:0]     size_q, size_d;
  logic [`REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [`BUS_DATA_WIDTH-1:0] fetch_data_q, fetch_data_d;
  logic [`REG_DATA_WIDTH-1:0] stbuf_data_q, stbuf_data_d;

  logic [ARB_SRC_NUM-1:0] req_vec, pick_gnt;
  logic                   pick_valid;

  assign req_vec = {fetch_arb_read_req, stbuf_arb_read_req, stbuf_arb_write_req};

  bus_rr_picker u_picker (
    .req_i       (req_vec),
    .last_grant_i(last_grant_q),
    .gnt_o       (pick_gnt),
    .valid_o     (pick_valid)
  );

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    fetch_data_d = fetch_data_q;
    stbuf_data_d = stbuf_data_q;
`ifdef BUS_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d      = onehot_to_src(pick_gnt);
          last_grant_d = grant_d;
          state_d      = BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
          cnt_d        = '0;
          err_d        = 1'b0;
`endif
          case (grant_d)
            SRC_STWR: begin
              addr_d  = stbuf_arb_write_addr;
              size_d  = stbuf_arb_write_size;
              wdata_d = stbuf_arb_data;
            end
            SRC_STRD: begin
              addr_d  = stbuf_arb_read_addr;
              size_d  = stbuf_arb_read_size;
              wdata_d = '0;
            end
            default: begin
              addr_d  = fetch_arb_addr;
              size_d  = `SIZE_WIDTH'(FETCH_SIZE);
              wdata_d = '0;
            end
          endcase
        end
      end
      BUSY: begin
        if (mem_arb_ack) begin
          state_d = DONE;
          if (grant_q == SRC_STRD)  stbuf_data_d = mem_arb_rdata[`REG_DATA_WIDTH-1:0];
          if (grant_q == SRC_FETCH) fetch_data_d = mem_arb_rdata;
`ifdef BUS_ARB_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the stalled transaction; reads return zero.
          state_d = DONE;
          err_d   = 1'b1;
          if (grant_q == SRC_STRD)  stbuf_data_d = '0;
          if (grant_q == SRC_FETCH) fetch_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= SRC_FETCH;
      grant_q      <= SRC_FETCH;
      addr_q       <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      fetch_data_q <= '0;
      stbuf_data_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      fetch_data_q <= fetch_data_d;
      stbuf_data_q <= stbuf_data_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign arb_bus_err = (state_q == DONE) && err_q;
`else
  assign arb_bus_err = 1'b0;
`endif

  // Strobes decode from the state register so reset drops them asynchronously.
  assign arb_mem_rd          = (state_q == BUSY) && (grant_q != SRC_STWR);
  assign arb_mem_wr          = (state_q == BUSY) && (grant_q == SRC_STWR);
  assign arb_stbuf_write_ack = (state_q == DONE) && (grant_q == SRC_STWR);
  assign arb_stbuf_read_ack  = (state_q == DONE) && (grant_q == SRC_STRD);
  assign arb_fetch_read_ack  = (state_q == DONE) && (grant_q == SRC_FETCH);

  assign arb_mem_addr   = addr_q;
  assign arb_mem_size   = size_q;
  assign arb_mem_data   = wdata_q;
  assign arb_fetch_data = fetch_data_q;
  assign arb_stbuf_data = stbuf_data_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected acks, a monitor pops them.
// Define BUS_ARB_TIMEOUT_EN to also exercise the timeout path.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 64
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 2
`endif

module tb_bus_arbiter;

  logic                       clk, rst;
  logic [`ADDR_WIDTH-1:0]     fetch_arb_addr;
  logic                       fetch_arb_read_req;
  logic [`BUS_DATA_WIDTH-1:0] arb_fetch_data;
  logic                       arb_fetch_read_ack;
  logic [`ADDR_WIDTH-1:0]     stbuf_arb_read_addr;
  logic [`SIZE_WIDTH-1:0]     stbuf_arb_read_size;
  logic                       stbuf_arb_read_req;
  logic [`REG_DATA_WIDTH-1:0] arb_stbuf_data;
  logic                       arb_stbuf_read_ack;
  logic [`ADDR_WIDTH-1:0]     stbuf_arb_write_addr;
  logic [`SIZE_WIDTH-1:0]     stbuf_arb_write_size;
  logic [`REG_DATA_WIDTH-1:0] stbuf_arb_data;
  logic                       stbuf_arb_write_req;
  logic                       arb_stbuf_write_ack;
  logic [`ADDR_WIDTH-1:0]     arb_mem_addr;
  logic [`SIZE_WIDTH-1:0]     arb_mem_size;
  logic [`REG_DATA_WIDTH-1:0] arb_mem_data;
  logic                       arb_mem_rd, arb_mem_wr;
  logic                       mem_arb_ack;
  logic [`BUS_DATA_WIDTH-1:0] mem_arb_rdata;
  logic                       arb_bus_err;

  bus_arbiter #(
    .FETCH_SIZE    (3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .fetch_arb_addr      (fetch_arb_addr),
    .fetch_arb_read_req  (fetch_arb_read_req),
    .arb_fetch_data      (arb_fetch_data),
    .arb_fetch_read_ack  (arb_fetch_read_ack),
    .stbuf_arb_read_addr (stbuf_arb_read_addr),
    .stbuf_arb_read_size (stbuf_arb_read_size),
    .stbuf_arb_read_req  (stbuf_arb_read_req),
    .arb_stbuf_data      (arb_stbuf_data),
    .arb_stbuf_read_ack  (arb_stbuf_read_ack),
    .stbuf_arb_write_addr(stbuf_arb_write_addr),
    .stbuf_arb_write_size(stbuf_arb_write_size),
    .stbuf_arb_data      (stbuf_arb_data),
    .stbuf_arb_write_req (stbuf_arb_write_req),
    .arb_stbuf_write_ack (arb_stbuf_write_ack),
    .arb_mem_addr        (arb_mem_addr),
    .arb_mem_size        (arb_mem_size),
    .arb_mem_data        (arb_mem_data),
    .arb_mem_rd          (arb_mem_rd),
    .arb_mem_wr          (arb_mem_wr),
    .mem_arb_ack         (mem_arb_ack),
    .mem_arb_rdata       (mem_arb_rdata),
    .arb_bus_err         (arb_bus_err)
  );

  typedef struct {
    int                         kind;  // 0 stwr, 1 strd, 2 fetch
    logic [`BUS_DATA_WIDTH-1:0] data;
    logic                       err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   wait_cycles = 0;
  bit   hang = 1'b0;
  int   busy_n;
  int   lat_a, lat_b, lat_c, lat_d;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic ack_of(input int kind);
    case (kind)
      0:       return arb_stbuf_write_ack;
      1:       return arb_stbuf_read_ack;
      default: return arb_fetch_read_ack;
    endcase
  endfunction

  task automatic set_req(input int kind, input logic v);
    case (kind)
      0:       stbuf_arb_write_req = v;
      1:       stbuf_arb_read_req  = v;
      default: fetch_arb_read_req  = v;
    endcase
  endtask

  // Call at a negedge; raises the request, waits (bounded) for its ack, then drops it.
  task automatic run_req(input int kind, output int lat);
    lat = -1;
    set_req(kind, 1'b1);
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (ack_of(kind)) begin
        lat = n;
        break;
      end
    end
    set_req(kind, 1'b0);
    if (lat < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout kind %0d: got no ack, required ack within 60 cycles", kind);
    end
  endtask

  function automatic exp_t mk(input int kind, input logic [`BUS_DATA_WIDTH-1:0] d,
                              input logic err);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.err  = err;
    return e;
  endfunction

  // Memory responder: ack in the BUSY cycle whose index equals wait_cycles.
  initial begin
    mem_arb_ack = 1'b0;
    busy_n      = 0;
    forever begin
      @(negedge clk);
      if (arb_mem_rd || arb_mem_wr) begin
        mem_arb_ack = !hang && (busy_n == wait_cycles);
        busy_n++;
      end else begin
        mem_arb_ack = 1'b0;
        busy_n      = 0;
      end
    end
  end

  // Monitor: every ack pops one scoreboard entry.
  initial begin
    exp_t e;
    int   n_acks, seen;
    forever begin
      @(negedge clk);
      if (!rst) begin
        n_acks = int'(arb_stbuf_write_ack) + int'(arb_stbuf_read_ack) + int'(arb_fetch_read_ack);
        if (n_acks == 0) begin
          if (arb_bus_err) check("err_without_ack", arb_bus_err, 1'b0);
        end else begin
          check("ack_onehot", n_acks, 1);
          seen = arb_stbuf_write_ack ? 0 : (arb_stbuf_read_ack ? 1 : 2);
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack: got ack kind %0d, required none", seen);
          end else begin
            e = sb_q.pop_front();
            check("ack_kind", seen, e.kind);
            check("bus_err", arb_bus_err, e.err);
            if (e.kind == 1) check("stbuf_data", arb_stbuf_data, e.data[`REG_DATA_WIDTH-1:0]);
            if (e.kind == 2) check("fetch_data", arb_fetch_data, e.data);
          end
        end
      end
    end
  end

  initial begin
    int wr_cnt, ack_n, done_n;
    bit stable;
    rst                  = 1'b1;
    fetch_arb_addr       = '0;
    fetch_arb_read_req   = 1'b0;
    stbuf_arb_read_addr  = '0;
    stbuf_arb_read_size  = '0;
    stbuf_arb_read_req   = 1'b0;
    stbuf_arb_write_addr = '0;
    stbuf_arb_write_size = '0;
    stbuf_arb_data       = '0;
    stbuf_arb_write_req  = 1'b0;
    mem_arb_rdata        = '0;
    repeat (2) @(negedge clk);
    check("reset_strobes", {arb_mem_rd, arb_mem_wr, arb_bus_err, arb_fetch_read_ack,
                            arb_stbuf_read_ack, arb_stbuf_write_ack}, 6'b0);
    check("reset_cmd", {arb_mem_addr, arb_mem_size, arb_mem_data}, '0);
    check("reset_data", {arb_fetch_data, arb_stbuf_data}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single fetch, ack in the first BUSY cycle.
    fetch_arb_addr = 32'h8000_0000;
    mem_arb_rdata  = 64'h1122_3344_5566_7788;
    sb_q.push_back(mk(2, 64'h1122_3344_5566_7788, 1'b0));
    fetch_arb_read_req = 1'b1;
    @(negedge clk);
    check("fetch_cmd_rd", {arb_mem_rd, arb_mem_wr}, 2'b10);
    check("fetch_cmd_size", arb_mem_size, 3);
    check("fetch_cmd_addr", arb_mem_addr, 32'h8000_0000);
    @(negedge clk);
    check("fetch_ack_at_2", arb_fetch_read_ack, 1'b1);
    check("fetch_rd_one_cycle", arb_mem_rd, 1'b0);
    fetch_arb_read_req = 1'b0;
    @(negedge clk);

    // All three held: stwr, strd, fetch, then re-raised stwr after fetch.
    mem_arb_rdata = 64'h0123_4567_89AB_CDEF;
    sb_q.push_back(mk(0, '0, 1'b0));
    sb_q.push_back(mk(1, 64'h0123_4567_89AB_CDEF, 1'b0));
    sb_q.push_back(mk(2, 64'h0123_4567_89AB_CDEF, 1'b0));
    sb_q.push_back(mk(0, '0, 1'b0));
    fork
      begin
        run_req(0, lat_a);
        check("rr_stwr_lat", lat_a, 2);
        @(negedge clk);
        run_req(0, lat_d);
        check("rr_stwr_again_lat", lat_d, 8);
      end
      begin
        run_req(1, lat_b);
        check("rr_strd_lat", lat_b, 5);
      end
      begin
        run_req(2, lat_c);
        check("rr_fetch_lat", lat_c, 8);
      end
    join
    @(negedge clk);

    // Store with 4 wait states; inputs scrambled after grant to prove latching.
    wait_cycles          = 4;
    stbuf_arb_write_addr = 32'h8000_1000;
    stbuf_arb_write_size = 2'd2;
    stbuf_arb_data       = 32'hDEAD_BEEF;
    sb_q.push_back(mk(0, '0, 1'b0));
    stbuf_arb_write_req = 1'b1;
    wr_cnt = 0;
    ack_n  = -1;
    done_n = -1;
    stable = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      #1;
      stbuf_arb_write_addr = 32'h1234_5678;
      stbuf_arb_data       = 32'h0BAD_F00D;
      if (arb_mem_wr) begin
        wr_cnt++;
        if (arb_mem_rd || arb_mem_addr !== 32'h8000_1000 || arb_mem_size !== 2'd2 ||
            arb_mem_data !== 32'hDEAD_BEEF) stable = 1'b0;
      end
      if (mem_arb_ack) ack_n = n;
      if (arb_stbuf_write_ack) begin
        done_n = n;
        break;
      end
    end
    stbuf_arb_write_req = 1'b0;
    check("store_wr_cycles", wr_cnt, 5);
    check("store_cmd_stable", stable, 1'b1);
    check("store_mem_ack_cycle", ack_n, 5);
    check("store_ack_after_mem_ack", done_n, ack_n + 1);
    wait_cycles = 0;
    @(negedge clk);

    // Asynchronous reset in the middle of BUSY.
    hang               = 1'b1;
    fetch_arb_addr     = 32'h8000_0040;
    fetch_arb_read_req = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", arb_mem_rd, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("reset_drops_rd_wr", {arb_mem_rd, arb_mem_wr}, 2'b00);
    check("reset_drops_acks", {arb_fetch_read_ack, arb_stbuf_read_ack, arb_stbuf_write_ack},
          3'b000);
    check("reset_clears_fetch_data", arb_fetch_data, '0);
    fetch_arb_read_req = 1'b0;
    @(negedge clk);
    hang          = 1'b0;
    rst           = 1'b0;
    mem_arb_rdata = 64'h0F0E_0D0C_0B0A_0908;
    sb_q.push_back(mk(0, '0, 1'b0));
    sb_q.push_back(mk(2, 64'h0F0E_0D0C_0B0A_0908, 1'b0));
    fork
      begin
        run_req(0, lat_a);
        check("post_reset_stwr_lat", lat_a, 2);
      end
      begin
        run_req(2, lat_b);
        check("post_reset_fetch_lat", lat_b, 5);
      end
    join
    @(negedge clk);

    // Load returns only the low register-width bits; fetch data untouched.
    stbuf_arb_read_addr = 32'h8000_2000;
    stbuf_arb_read_size = 2'd2;
    mem_arb_rdata       = 64'hAAAA_BBBB_CCCC_DDDD;
    sb_q.push_back(mk(1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0));
    run_req(1, lat_a);
    check("load_lat", lat_a, 2);
    check("load_data_low", arb_stbuf_data, 32'hCCCC_DDDD);
    check("load_keeps_fetch_data", arb_fetch_data, 64'h0F0E_0D0C_0B0A_0908);
    @(negedge clk);
    mem_arb_rdata = 64'h5555_6666_7777_8888;
    sb_q.push_back(mk(2, 64'h5555_6666_7777_8888, 1'b0));
    run_req(2, lat_a);
    check("fetch_keeps_load_data", arb_stbuf_data, 32'hCCCC_DDDD);
    @(negedge clk);

`ifdef BUS_ARB_TIMEOUT_EN
    // No ack: 8 BUSY cycles then an error completion with zero data.
    hang = 1'b1;
    sb_q.push_back(mk(2, '0, 1'b1));
    run_req(2, lat_a);
    check("timeout_lat", lat_a, 9);
    @(negedge clk);
    check("timeout_back_idle", {arb_mem_rd, arb_mem_wr, arb_fetch_read_ack}, 3'b000);
    // Ack arriving in the timeout cycle completes normally.
    hang          = 1'b0;
    wait_cycles   = 7;
    mem_arb_rdata = 64'h0000_0000_1357_9BDF;
    sb_q.push_back(mk(1, 64'h0000_0000_1357_9BDF, 1'b0));
    run_req(1, lat_b);
    check("ack_beats_timeout_lat", lat_b, 9);
    wait_cycles = 0;
    @(negedge clk);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
